fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control block for the fetch stage. Each cycle it selects the next PC value from sequential, branch/jump, interrupt vector or reset. It owns the interrupt-entry sequence: drain, flush, save the 32-bit return PC as two 16-bit stack pushes, then redirect to the vector. It drives the PC register's load value and stall, and the fetch/decode flush.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `INT_VECTOR`, default 32'h0000_0002: PC loaded on interrupt entry.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `intr_req` in 1: external interrupt request, level; held until `intr_ack`.
- `jump_taken` in 1: resolved branch/jump this cycle.
- `jump_target` in 32: target for `jump_taken`.
- `hazard_stall` in 1: downstream load-use stall.
- `imm_pending` in 1: fetched word is the first half of a two-word (immediate) instruction.
- `pc_plus1` in 32: current PC + 1, from the PC register.
- `pc_load` out 32: next PC value.
- `pc_stall` out 1: hold the PC register.
- `flush_fd` out 1: squash the fetch/decode register.
- `push_valid` out 1: stack-push request to memory stage.
- `push_data` out 16: word to push.
- `push_ready` in 1: memory stage accepts the push this cycle.
- `intr_ack` out 1: one-cycle pulse, interrupt entry complete.
- `busy` out 1: high in any state except RUN.

## Operation
States: RUN, DRAIN, PUSH_HI, PUSH_LO, VECTOR.

RUN:
- `pc_load` priority is `jump_taken` (`jump_target`), then `pc_plus1`.
- `pc_stall = hazard_stall`.
- `flush_fd = jump_taken`.
- If `intr_req` is high, go to DRAIN. In the same cycle, latch `ret_pc`: `jump_target` if `jump_taken`, else `pc_plus1`.

DRAIN:
- `pc_stall = 1`, `flush_fd = 1`.
- Leave for PUSH_HI when `imm_pending = 0` and `hazard_stall = 0`.
- A `jump_taken` seen in DRAIN overwrites `ret_pc` with `jump_target`.

PUSH_HI:
- `push_valid = 1`, `push_data = ret_pc[31:16]`, `pc_stall = 1`, `flush_fd = 1`.
- On `push_ready`, go to PUSH_LO.

PUSH_LO:
- Same, with `push_data = ret_pc[15:0]`.
- On `push_ready`, go to VECTOR.

VECTOR:
- `pc_load = INT_VECTOR`, `pc_stall = 0`, `flush_fd = 1`, `intr_ack = 1`.
- Go to RUN unconditionally.

General rules:
- `intr_req` is sampled only in RUN. A request still high on return to RUN starts a new entry.
- `push_data` and `push_valid` stay stable while `push_valid = 1` and `push_ready = 0`.
- `ret_pc` is a 32-bit register. No arithmetic beyond selection; `pc_plus1` wrap is the PC register's concern.

## Timing
Reset (`rst` = 1 at a rising edge):
- State goes to RUN, `ret_pc = 0`.
- `pc_load = RESET_PC`, `pc_stall = 0`, `flush_fd = 1` during reset cycles.
- `push_valid = 0`, `intr_ack = 0`, `busy = 0`.
- Reset overrides all inputs, including mid-push. A partially pushed return PC is abandoned and no ack is issued.

Interrupt latency:
- Minimum from `intr_req` high in RUN to `pc_load = INT_VECTOR`: 4 cycles (RUN→DRAIN→PUSH_HI→PUSH_LO→VECTOR), with `push_ready` constantly 1 and no drain wait.
- Each cycle of `imm_pending`, `hazard_stall` or `push_ready` = 0 adds one cycle.

Outputs:
- All outputs are a combinational function of state, registered `ret_pc` and current inputs. No input-to-state path bypasses a register.
- `jump_taken` and `intr_req` in the same RUN cycle: the jump wins for `pc_load`, and `ret_pc = jump_target`.
- `hazard_stall` in VECTOR is ignored; the redirect always completes.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fseq_state_t` (RUN=0, DRAIN=1, PUSH_HI=2, PUSH_LO=3, VECTOR=4).
  - constants `PC_W = 32`, `WORD_W = 16`.
- Single module, no sub-modules:
  - one state register block;
  - one `ret_pc` capture block;
  - one combinational output decoder.

## Test plan
- Reset: `rst` = 1 for 2 cycles with `intr_req` = 1 → `pc_load` = 0, `flush_fd` = 1, `busy` = 0; state is RUN after release.
- Plain jump: `pc_plus1` = 0x10, `jump_taken` = 1, `jump_target` = 0x40 → `pc_load` = 0x40, `flush_fd` = 1 for that cycle only.
- Interrupt entry, `push_ready` = 1, `pc_plus1` = 0x0001_2345:
  - pushes 0x0001 then 0x2345 on consecutive cycles;
  - `pc_load` = 0x2 with `intr_ack` in cycle 4.
- Drain: `intr_req` while `imm_pending` = 1 for 3 cycles → PUSH_HI entered on the cycle after `imm_pending` falls; total latency 7.
- Backpressure: `push_ready` = 0 for 2 cycles during PUSH_LO → `push_data` held at the low word; `intr_ack` delayed by 2.
- Simultaneous `jump_taken` (target 0x80) and `intr_req` → pushes 0x0000, then 0x0080.
- Reset asserted during PUSH_LO → no `intr_ack`; next cycle `pc_load` = `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the fetch-stage sequencer.
package fetch_pkg;

    localparam int PC_W   = 32;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        DRAIN   = 3'd1,
        PUSH_HI = 3'd2,
        PUSH_LO = 3'd3,
        VECTOR  = 3'd4
    } fseq_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch-stage next-PC selection and interrupt entry: drain, push the return PC
// as two stack words, then redirect to the interrupt vector.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [PC_W-1:0] INT_VECTOR = 32'h0000_0002
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              intr_req,
    input  logic              jump_taken,
    input  logic [PC_W-1:0]   jump_target,
    input  logic              hazard_stall,
    input  logic              imm_pending,
    input  logic [PC_W-1:0]   pc_plus1,
    output logic [PC_W-1:0]   pc_load,
    output logic              pc_stall,
    output logic              flush_fd,
    output logic              push_valid,
    output logic [WORD_W-1:0] push_data,
    input  logic              push_ready,
    output logic              intr_ack,
    output logic              busy
);

    fseq_state_t     state;
    fseq_state_t     stateNext;
    logic [PC_W-1:0] retPc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= stateNext;
    end

    // A jump resolved while draining is the real return point, so it replaces
    // the PC captured when the request was first seen.
    always_ff @(posedge clk) begin
        if (rst)
            retPc <= '0;
        else if (state == RUN && intr_req)
            retPc <= jump_taken ? jump_target : pc_plus1;
        else if (state == DRAIN && jump_taken)
            retPc <= jump_target;
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned and a latch cannot be inferred.
    always_comb begin
        stateNext  = state;
        pc_load    = pc_plus1;
        pc_stall   = 1'b0;
        flush_fd   = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        intr_ack   = 1'b0;
        busy       = (state != RUN);

        if (rst) begin
            pc_load  = RESET_PC;
            flush_fd = 1'b1;
            busy     = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    pc_load  = jump_taken ? jump_target : pc_plus1;
                    pc_stall = hazard_stall;
                    flush_fd = jump_taken;
                    if (intr_req) stateNext = DRAIN;
                end
                DRAIN: begin
                    pc_stall = 1'b1;
                    flush_fd = 1'b1;
                    if (!imm_pending && !hazard_stall) stateNext = PUSH_HI;
                end
                PUSH_HI: begin
                    pc_stall   = 1'b1;
                    flush_fd   = 1'b1;
                    push_valid = 1'b1;
                    push_data  = retPc[PC_W-1:WORD_W];
                    if (push_ready) stateNext = PUSH_LO;
                end
                PUSH_LO: begin
                    pc_stall   = 1'b1;
                    flush_fd   = 1'b1;
                    push_valid = 1'b1;
                    push_data  = retPc[WORD_W-1:0];
                    if (push_ready) stateNext = VECTOR;
                end
                VECTOR: begin
                    pc_load   = INT_VECTOR;
                    flush_fd  = 1'b1;
                    intr_ack  = 1'b1;
                    stateNext = RUN;
                end
                default: stateNext = RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: directed interrupt-entry scenarios plus random traffic,
// all compared cycle by cycle against a queue-based behavioural model.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] INT_VECTOR = 32'h0000_0002;

    logic        clk = 1'b0;
    logic        rst, intr_req, jump_taken, hazard_stall, imm_pending, push_ready;
    logic [31:0] jump_target, pc_plus1, pc_load;
    logic        pc_stall, flush_fd, push_valid, intr_ack, busy;
    logic [15:0] push_data;

    int testsRun = 0;
    int testsFailed = 0;

    // Model: draining flag, queue of words still to push, pending redirect.
    bit          mDrain;
    bit          mVec;
    logic [15:0] pushQ[$];
    logic [31:0] mRet;
    logic        lastAck;

    fetch_sequencer #(.RESET_PC(RESET_PC), .INT_VECTOR(INT_VECTOR)) dut (
        .clk(clk), .rst(rst), .intr_req(intr_req), .jump_taken(jump_taken),
        .jump_target(jump_target), .hazard_stall(hazard_stall),
        .imm_pending(imm_pending), .pc_plus1(pc_plus1), .pc_load(pc_load),
        .pc_stall(pc_stall), .flush_fd(flush_fd), .push_valid(push_valid),
        .push_data(push_data), .push_ready(push_ready), .intr_ack(intr_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        logic [31:0] ePc;
        logic        eStall, eFlush, eValid, eAck, eBusy, pcDefined;
        logic [15:0] eData;
        #1;
        pcDefined = 1'b1;
        eData     = '0;
        eValid    = 1'b0;
        eAck      = 1'b0;
        ePc       = pc_plus1;
        if (rst) begin
            ePc = RESET_PC; eStall = 0; eFlush = 1; eBusy = 0;
        end else if (mVec) begin
            ePc = INT_VECTOR; eStall = 0; eFlush = 1; eAck = 1; eBusy = 1;
        end else if (pushQ.size() != 0) begin
            pcDefined = 0; eStall = 1; eFlush = 1; eValid = 1; eData = pushQ[0]; eBusy = 1;
        end else if (mDrain) begin
            pcDefined = 0; eStall = 1; eFlush = 1; eBusy = 1;
        end else begin
            ePc = jump_taken ? jump_target : pc_plus1;
            eStall = hazard_stall; eFlush = jump_taken; eBusy = 0;
        end
        if (pcDefined) check("pc_load", pc_load, ePc);
        check("pc_stall", {31'b0, pc_stall}, {31'b0, eStall});
        check("flush_fd", {31'b0, flush_fd}, {31'b0, eFlush});
        check("push_valid", {31'b0, push_valid}, {31'b0, eValid});
        if (eValid) check("push_data", {16'b0, push_data}, {16'b0, eData});
        check("intr_ack", {31'b0, intr_ack}, {31'b0, eAck});
        check("busy", {31'b0, busy}, {31'b0, eBusy});
        lastAck = intr_ack;

        @(posedge clk);
        if (rst) begin
            mDrain = 0; mVec = 0; pushQ.delete(); mRet = '0;
        end else if (mVec) begin
            mVec = 0;
        end else if (pushQ.size() != 0) begin
            if (push_ready) begin
                void'(pushQ.pop_front());
                if (pushQ.size() == 0) mVec = 1;
            end
        end else if (mDrain) begin
            if (jump_taken) mRet = jump_target;
            if (!imm_pending && !hazard_stall) begin
                mDrain = 0;
                pushQ.push_back(mRet[31:16]);
                pushQ.push_back(mRet[15:0]);
            end
        end else if (intr_req) begin
            mRet   = jump_taken ? jump_target : pc_plus1;
            mDrain = 1;
        end
        @(negedge clk);
    endtask

    task automatic idleInputs();
        rst = 0; intr_req = 0; jump_taken = 0; jump_target = '0;
        hazard_stall = 0; imm_pending = 0; push_ready = 1;
    endtask

    // Full interrupt entry; imm_pending high for the first immCycles drain
    // cycles, push_ready low for bpCycles while the low word is offered.
    task automatic entry(input int immCycles, input int bpCycles, input int expLat);
        int lat = -1;
        int bp  = bpCycles;
        intr_req = 1;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            imm_pending = (c >= 1 && c <= immCycles);
            push_ready  = 1;
            if (pushQ.size() == 1 && bp > 0) begin
                push_ready = 0;
                bp--;
            end
            step();
            jump_taken = 0;
            if (lastAck) lat = c;
        end
        idleInputs();
        check("entry_latency", lat, expLat);
    endtask

    initial begin
        mDrain = 0; mVec = 0; mRet = '0; lastAck = 0;
        idleInputs();
        @(negedge clk);

        // Reset held with an interrupt pending.
        rst = 1; intr_req = 1; pc_plus1 = 32'h55;
        step(); step();
        idleInputs();
        step();
        check("busy_after_reset", {31'b0, busy}, 32'd0);

        // Plain jump, then the following sequential cycle.
        pc_plus1 = 32'h10; jump_taken = 1; jump_target = 32'h40;
        step();
        jump_taken = 0; pc_plus1 = 32'h41;
        step();

        // Minimum-latency entry with a recognisable return PC.
        pc_plus1 = 32'h0001_2345;
        entry(0, 0, 4);
        pc_plus1 = 32'h3;
        step();

        // Drain held by imm_pending for three cycles.
        pc_plus1 = 32'h0000_0777;
        entry(3, 0, 7);

        // Backpressure on the low-word push.
        pc_plus1 = 32'hABCD_0001;
        entry(0, 2, 6);

        // Jump and interrupt together: return PC is the jump target.
        pc_plus1 = 32'h0000_0011; jump_taken = 1; jump_target = 32'h80;
        entry(0, 0, 4);

        // Reset while the low word is being offered abandons the entry.
        pc_plus1 = 32'h0000_1234; intr_req = 1; push_ready = 0;
        for (int c = 0; c < 20 && pushQ.size() != 1; c++) begin
            push_ready = (pushQ.size() == 2);
            step();
        end
        check("reached_push_lo", pushQ.size(), 32'd1);
        rst = 1;
        step();
        idleInputs();
        pc_plus1 = 32'h1;
        step(); step();

        // Random traffic with a level request held until acknowledged.
        for (int c = 0; c < 400; c++) begin
            if (lastAck || rst) intr_req = 0;
            else if (!intr_req) intr_req = ($urandom_range(0, 9) == 0);
            rst          = ($urandom_range(0, 59) == 0);
            jump_taken   = ($urandom_range(0, 3) == 0);
            jump_target  = $urandom;
            pc_plus1     = $urandom;
            hazard_stall = ($urandom_range(0, 3) == 0);
            imm_pending  = ($urandom_range(0, 3) == 0);
            push_ready   = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
